// File: rtl/stack_queue_alu.sv
// stack_queue_alu: parametrised LIFO/FIFO operand store with an in-line ADD/SUB ALU.
// Commands use a valid/ready handshake; rejected commands pulse err and change nothing else.
module stack_queue_alu #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_op,
  input  logic [WIDTH-1:0]       cmd_data,
  output logic                   cmd_ready,
  output logic [WIDTH-1:0]       result_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_SUB  = 2'd3;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_A = 2'd1,
    ST_RD_B = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mode_q, mode_d;
  logic             op_sub_q, op_sub_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             accept_s;
  logic [AW-1:0]    sp_top_s;
  logic [AW-1:0]    rd_addr_s;
  logic [AW-1:0]    wr_addr_s;
  logic [WIDTH-1:0] rd_data_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             mem_we_s;
  logic [WIDTH-1:0] mem_wdata_s;

  // In stack mode the stack pointer is the occupancy itself.
  assign accept_s  = cmd_valid & ready_q;
  assign sp_top_s  = count_q[AW-1:0] - PTR_ONE;
  assign rd_addr_s = mode_q ? head_q : sp_top_s;
  assign wr_addr_s = mode_q ? tail_q : count_q[AW-1:0];
  assign rd_data_s = mem_q[rd_addr_s];

  // opa holds the newer operand in stack mode and the older one in queue mode.
  always_comb begin
    if (op_sub_q) begin
      if (mode_q) begin
        alu_res_s = opa_q - opb_q;
      end else begin
        alu_res_s = opb_q - opa_q;
      end
    end else begin
      alu_res_s = opa_q + opb_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && cmd_op[1] && (count_q >= CNT_TWO)) begin
          state_d = ST_RD_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_A: state_d = ST_RD_B;
      ST_RD_B: state_d = ST_WR;
      ST_WR:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    op_sub_d    = op_sub_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    result_d    = result_q;
    err_d       = 1'b0;
    mem_we_s    = 1'b0;
    mem_wdata_s = cmd_data;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_PUSH: begin
              if (full_q) begin
                err_d = 1'b1;
              end else begin
                mem_we_s = 1'b1;
                result_d = cmd_data;
                count_d  = count_q + CNT_ONE;
                tail_d   = mode_q ? (tail_q + PTR_ONE) : tail_q;
              end
            end
            OP_POP: begin
              if (empty_q) begin
                err_d = 1'b1;
              end else begin
                result_d = rd_data_s;
                count_d  = count_q - CNT_ONE;
                head_d   = mode_q ? (head_q + PTR_ONE) : head_q;
              end
            end
            OP_ADD, OP_SUB: begin
              if (count_q < CNT_TWO) begin
                err_d = 1'b1;
              end else begin
                op_sub_d = cmd_op[0];
              end
            end
            default: err_d = 1'b0;
          endcase
        end else begin
          err_d = 1'b0;
        end
      end
      ST_RD_A: begin
        opa_d   = rd_data_s;
        count_d = count_q - CNT_ONE;
        head_d  = mode_q ? (head_q + PTR_ONE) : head_q;
      end
      ST_RD_B: begin
        opb_d   = rd_data_s;
        count_d = count_q - CNT_ONE;
        head_d  = mode_q ? (head_q + PTR_ONE) : head_q;
      end
      ST_WR: begin
        mem_we_s    = 1'b1;
        mem_wdata_s = alu_res_s;
        result_d    = alu_res_s;
        count_d     = count_q + CNT_ONE;
        tail_d      = mode_q ? (tail_q + PTR_ONE) : tail_q;
      end
      default: err_d = 1'b0;
    endcase
  end

  // Mode may only change while the store is empty and no ALU sequence is running.
  always_comb begin
    if ((state_q == ST_IDLE) && (count_q == CNT_ZERO)) begin
      mode_d = mode;
    end else begin
      mode_d = mode_q;
    end
    empty_d = (count_d == CNT_ZERO);
    full_d  = (count_d == CNT_FULL);
    ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      head_q   <= {AW{1'b0}};
      tail_q   <= {AW{1'b0}};
      count_q  <= CNT_ZERO;
      mode_q   <= 1'b0;
      op_sub_q <= 1'b0;
      opa_q    <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      err_q    <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      op_sub_q <= op_sub_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      err_q    <= err_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ready_q  <= ready_d;
    end
  end

  // Operand storage; contents are meaningless after reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && rst) begin
      mem_q[wr_addr_s] <= mem_wdata_s;
    end
  end

  assign cmd_ready   = ready_q;
  assign result_data = result_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign err         = err_q;

endmodule
